// File: rtl/morse_capture_pkg.sv
// Shared morse symbol encodings and capture FSM states.
// Also used by the playback decomposer so both ends agree.
package morse_capture_pkg;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;

  localparam int MAX_SYMS = 5;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } state_t;

endpackage

// File: rtl/morse_capture_key_debounce.sv
// Key synchronizer and debouncer for morse_capture.
// Debouncer is present only when MORSE_CAPTURE_DEBOUNCE_EN is defined.
module key_debounce #(
  parameter int DEBOUNCE = 500000,
  parameter int CW       = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic key_db
);

  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b00;
    else       sync <= {sync[0], key};
  end

`ifdef MORSE_CAPTURE_DEBOUNCE_EN
  logic [CW-1:0] cnt;
  logic          db;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (sync[1] == db) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE - 1)) begin
      cnt <= '0;
      db  <= sync[1];
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign key_db = db;
`else
  logic unused_cfg;

  assign unused_cfg = (DEBOUNCE > 0) ^ (CW > 0);
  assign key_db     = sync[1];
`endif

endmodule

// File: rtl/morse_capture.sv
// Morse keyer receiver: times key presses into a 10-bit morse word.
// Debouncing is enabled by defining MORSE_CAPTURE_DEBOUNCE_EN.
module morse_capture
  import morse_capture_pkg::*;
#(
  parameter int DEBOUNCE   = 500000,
  parameter int DOT_MAX    = 10000000,
  parameter int LETTER_GAP = 30000000,
  parameter int CW         = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key,
  output logic [9:0] morse,
  output logic       valid,
  output logic       busy,
  output logic [2:0] nsym,
  output logic       key_db
);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [9:0]    sbuf;
  logic [9:0]    sbuf_nx;
  logic [1:0]    sym;
  logic          db_q;
  logic          rise;
  logic          fall;
  logic          gap_end;
  logic          last;

  key_debounce #(
    .DEBOUNCE(DEBOUNCE),
    .CW      (CW)
  ) u_key_debounce (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .key_db(key_db)
  );

  assign rise    = key_db & ~db_q;
  assign fall    = ~key_db & db_q;
  assign gap_end = (cnt == CW'(LETTER_GAP - 1));
  assign last    = (nsym == 3'(MAX_SYMS - 1));
  assign sym     = (cnt >= CW'(DOT_MAX)) ? SYM_DASH : SYM_DOT;
  assign sbuf_nx = sbuf | ({8'b0, sym} << {nsym, 1'b0});

  // cnt is loaded with 1 on entry so it measures cycles since the event
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sbuf  <= {MAX_SYMS{SYM_NONE}};
      nsym  <= 3'd0;
      morse <= {MAX_SYMS{SYM_NONE}};
      valid <= 1'b0;
      busy  <= 1'b0;
      db_q  <= 1'b0;
    end else begin
      db_q  <= key_db;
      valid <= 1'b0;
      if (cnt != '1) cnt <= cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS;
            busy  <= 1'b1;
            cnt   <= CW'(1);
          end
        end
        PRESS: begin
          if (fall) begin
            cnt <= CW'(1);
            if (last) begin
              state <= IDLE;
              busy  <= 1'b0;
              morse <= sbuf_nx;
              valid <= 1'b1;
              sbuf  <= '0;
              nsym  <= 3'd0;
            end else begin
              state <= GAP;
              sbuf  <= sbuf_nx;
              nsym  <= nsym + 3'd1;
            end
          end
        end
        GAP: begin
          if (gap_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= CW'(1);
            morse <= sbuf;
            valid <= 1'b1;
            sbuf  <= '0;
            nsym  <= 3'd0;
          end else if (rise) begin
            state <= PRESS;
            cnt   <= CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_capture.sv
// Self-checking bench for morse_capture: directed cases plus random presses.
// Works with or without MORSE_CAPTURE_DEBOUNCE_EN.
module tb_morse_capture;

  localparam int DEBOUNCE   = 3;
  localparam int DOT_MAX    = 8;
  localparam int LETTER_GAP = 20;
  localparam int CW         = 5;
`ifdef MORSE_CAPTURE_DEBOUNCE_EN
  localparam int LAT = 2 + DEBOUNCE;
`else
  localparam int LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       key;
  logic [9:0] morse;
  logic       valid;
  logic       busy;
  logic [2:0] nsym;
  logic       key_db;

  morse_capture #(
    .DEBOUNCE  (DEBOUNCE),
    .DOT_MAX   (DOT_MAX),
    .LETTER_GAP(LETTER_GAP),
    .CW        (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .key   (key),
    .morse (morse),
    .valid (valid),
    .busy  (busy),
    .nsym  (nsym),
    .key_db(key_db)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;
  int n_valid = 0;
  int last_valid_cyc = 0;
  logic [9:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      check("queue_nonempty", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check("word", 32'(morse), 32'(exp_q.pop_front()));
      check("nsym_after_pub", 32'(nsym), 0);
      check("busy_after_pub", 32'(busy), 0);
    end
  end

  task automatic drive(input logic v, input int n);
    key = v;
    repeat (n) @(negedge clk);
  endtask

  // reference model: press/release lengths -> expected characters
  logic [1:0] m_syms[$];
  bit         m_skip = 1'b0;

  task automatic flush();
    logic [9:0] w;
    w = '0;
    foreach (m_syms[i]) w[2*i +: 2] = m_syms[i];
    exp_q.push_back(w);
    m_syms.delete();
  endtask

  task automatic model_press(input int h, input int l);
    if (m_skip) begin
      m_skip = 1'b0;
      return;
    end
    m_syms.push_back((h < DOT_MAX) ? 2'b01 : 2'b10);
    if (m_syms.size() == 5) begin
      flush();
    end else if (l >= LETTER_GAP - 1) begin
      flush();
      m_skip = (l == LETTER_GAP - 1);
    end
  endtask

  int base;
  int t_fall;

  initial begin
    reset = 1'b1;
    key   = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      key = 1'($urandom);
      @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_valid", 32'(valid), 0);
    end
    check("rst_morse", 32'(morse), 0);
    check("rst_nsym", 32'(nsym), 0);
    check("rst_key_db", 32'(key_db), 0);
    reset = 1'b0;
    drive(0, 10);
    check("idle_busy", 32'(busy), 0);

    // dot then dash
    base = n_valid;
    exp_q.push_back(10'b00_00_00_10_01);
    drive(1, 4);
    drive(0, 10);
    drive(1, 15);
    t_fall = cyc + LAT;
    drive(0, 30);
    check("dd_count", 32'(n_valid - base), 1);
    check("dd_timing", 32'(last_valid_cyc - t_fall), LETTER_GAP);
    check("dd_nsym", 32'(nsym), 0);

    // five dots publish right after the fifth fall
    base = n_valid;
    exp_q.push_back(10'b01_01_01_01_01);
    for (int i = 0; i < 4; i++) begin
      drive(1, 4);
      drive(0, 6);
    end
    drive(1, 4);
    t_fall = cyc + LAT;
    drive(0, LETTER_GAP + 10);
    check("five_count", 32'(n_valid - base), 1);
    check("five_timing", 32'(last_valid_cyc - t_fall), 1);

    // bounce
    base = n_valid;
`ifdef MORSE_CAPTURE_DEBOUNCE_EN
    exp_q.push_back(10'b00_00_00_00_01);
`else
    exp_q.push_back(10'b01_01_01_01_01);
    exp_q.push_back(10'b00_00_00_00_01);
`endif
    for (int i = 0; i < 10; i++) drive(1'(i % 2 == 0), 1);
    drive(1, 4);
    drive(0, LETTER_GAP + 10);
`ifdef MORSE_CAPTURE_DEBOUNCE_EN
    check("bounce_count", 32'(n_valid - base), 1);
`else
    check("bounce_count", 32'(n_valid - base), 2);
`endif

    // dot/dash threshold
    base = n_valid;
    exp_q.push_back(10'b00_00_00_00_01);
    exp_q.push_back(10'b00_00_00_00_10);
    drive(1, DOT_MAX - 1);
    drive(0, LETTER_GAP + 10);
    drive(1, DOT_MAX);
    drive(0, LETTER_GAP + 10);
    check("bound_count", 32'(n_valid - base), 2);

    // reset in the middle of a character
    base = n_valid;
    drive(1, 4);
    drive(0, 6);
    drive(1, 4);
    drive(0, 6);
    check("mid_nsym", 32'(nsym), 2);
    check("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    drive(0, 2);
    reset = 1'b0;
    check("mid_rst_nsym", 32'(nsym), 0);
    check("mid_rst_busy", 32'(busy), 0);
    drive(0, LETTER_GAP + 10);
    check("mid_no_valid", 32'(n_valid - base), 0);
    exp_q.push_back(10'b00_00_00_00_10);
    drive(1, 15);
    drive(0, LETTER_GAP + 10);
    check("mid_next_count", 32'(n_valid - base), 1);

    // random presses against the model
    for (int i = 0; i < 150; i++) begin
      int h;
      int l;
      h = ($urandom_range(0, 9) == 0) ? 40 : int'($urandom_range(4, 14));
      case ($urandom_range(0, 7))
        0:       l = LETTER_GAP - 2;
        1:       l = LETTER_GAP - 1;
        2:       l = LETTER_GAP;
        3:       l = LETTER_GAP + 5;
        default: l = int'($urandom_range(4, 10));
      endcase
      if (i == 149) l = LETTER_GAP + 10;
      model_press(h, l);
      drive(1, h);
      drive(0, l);
    end
    drive(0, 5);
    check("drain", 32'(exp_q.size()), 0);
    check("end_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
